// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared constants and one-hot helper for decoder_n_scan
package decoder_pkg;

  // Mode pin encoding
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Operating state encoding
  localparam logic [1:0] ST_OFF    = 2'b00;
  localparam logic [1:0] ST_DIRECT = 2'b01;
  localparam logic [1:0] ST_SCAN   = 2'b10;

  // Widest address the helper below can decode; instances slice the low OUTS bits.
  localparam int MAX_N    = 8;
  localparam int MAX_OUTS = 1 << MAX_N;

  // One-hot decode of an index into a MAX_OUTS-wide vector.
  function automatic logic [MAX_OUTS-1:0] onehot(input logic [MAX_N-1:0] idx);
    logic [MAX_OUTS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/scan_dwell_counter.sv
// rtl/scan_dwell_counter.sv - dwell timer producing one tick every HOLD running cycles
module scan_dwell_counter
  import decoder_pkg::*;
#(
  parameter int HOLD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  // A single-cycle dwell still needs one counter bit so the logic stays uniform.
  localparam int            DW   = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [DW-1:0] LAST = DW'(HOLD - 1);

  logic [DW-1:0] dwell_q;
  logic [DW-1:0] dwell_d;

  // The last dwell cycle only counts while the scan is actually running.
  assign tick = run && (dwell_q == LAST);

  // Count 0..HOLD-1 while running, restart after the last cycle, clear when idle.
  always_comb begin
    dwell_d = dwell_q;
    if (!run) begin
      dwell_d = '0;
    end else if (tick) begin
      dwell_d = '0;
    end else begin
      dwell_d = dwell_q + 1'b1;
    end
  end

  // Dwell register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_q <= '0;
    end else begin
      dwell_q <= dwell_d;
    end
  end

endmodule

// File: rtl/decoder_n_scan.sv
// rtl/decoder_n_scan.sv - registered N-to-2^N decoder with handshake and self-timed scan
module decoder_n_scan
  import decoder_pkg::*;
#(
  parameter  int N    = 2,
  parameter  int HOLD = 4,
  localparam int OUTS = 2 ** N
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            mode,
  input  logic            addr_valid,
  input  logic [N-1:0]    addr,
  output logic            addr_ready,
  output logic [OUTS-1:0] dout,
  output logic [N-1:0]    cur_idx,
  output logic            wrap
);

  logic [1:0]          state_q;
  logic [1:0]          state_d;
  logic [N-1:0]        cur_idx_q;
  logic [N-1:0]        cur_idx_d;
  logic [OUTS-1:0]     dout_q;
  logic [OUTS-1:0]     dout_d;
  logic                wrap_q;
  logic                wrap_d;

  logic                scan_now;
  logic                direct_now;
  logic                accept;
  logic                run;
  logic                tick;
  logic [MAX_N-1:0]    idx_ext;
  logic [MAX_OUTS-1:0] oh_full;

  // The state for this edge follows the pins directly; there are no transition guards.
  assign scan_now   = en && (mode == MODE_SCAN);
  assign direct_now = en && (mode == MODE_DIRECT);
  assign addr_ready = en && (mode == MODE_DIRECT) && !rst;
  assign accept     = direct_now && addr_valid;

  // The dwell timer only runs once SCAN has been held for at least one edge, so the
  // entry edge drives the current line and the full HOLD dwell starts after it.
  assign run = scan_now && (state_q == ST_SCAN);

  scan_dwell_counter #(
    .HOLD (HOLD)
  ) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .tick (tick)
  );

  // Next state, index and wrap pulse; a mode change on the last dwell cycle cancels the step.
  always_comb begin
    state_d   = ST_OFF;
    cur_idx_d = cur_idx_q;
    wrap_d    = 1'b0;
    if (scan_now) begin
      state_d = ST_SCAN;
    end else if (direct_now) begin
      state_d = ST_DIRECT;
    end
    case (state_d)
      ST_DIRECT: begin
        if (accept) begin
          cur_idx_d = addr;
        end
      end
      ST_SCAN: begin
        if (tick) begin
          cur_idx_d = cur_idx_q + 1'b1;
          wrap_d    = (cur_idx_q == {N{1'b1}});
        end
      end
      default: begin
        cur_idx_d = cur_idx_q;
      end
    endcase
  end

  // Decode the index the output will carry after this edge.
  always_comb begin
    idx_ext          = '0;
    idx_ext[N-1:0]   = cur_idx_d;
    oh_full          = onehot(idx_ext);
  end

  generate
    if (OUTS < MAX_OUTS) begin : g_oh_hi
      logic unused_oh_hi;
      assign unused_oh_hi = ^oh_full[MAX_OUTS-1:OUTS];
    end
  endgenerate

  // Output line selection: blank when off, refresh on accept or while scanning, else hold.
  always_comb begin
    dout_d = dout_q;
    case (state_d)
      ST_DIRECT: begin
        if (accept) begin
          dout_d = oh_full[OUTS-1:0];
        end
      end
      ST_SCAN: begin
        dout_d = oh_full[OUTS-1:0];
      end
      default: begin
        dout_d = '0;
      end
    endcase
  end

  // State and output registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_OFF;
      cur_idx_q <= '0;
      dout_q    <= '0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_idx_q <= cur_idx_d;
      dout_q    <= dout_d;
      wrap_q    <= wrap_d;
    end
  end

  assign dout    = dout_q;
  assign cur_idx = cur_idx_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_decoder_n_scan.sv
// tb/tb_decoder_n_scan.sv - self-checking bench for decoder_n_scan
module tb_decoder_n_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: N=2, HOLD=3
  logic       rst0, en0, mode0, v0, rdy0, wrap0;
  logic [1:0] addr0, idx0;
  logic [3:0] dout0;
  // Instance 1: N=3, HOLD=1
  logic       rst1, en1, mode1, v1, rdy1, wrap1;
  logic [2:0] addr1, idx1;
  logic [7:0] dout1;
  // Instance 2: N=1, HOLD=2
  logic       rst2, en2, mode2, v2, rdy2, wrap2;
  logic [0:0] addr2, idx2;
  logic [1:0] dout2;

  decoder_n_scan #(.N(2), .HOLD(3)) dut0 (
    .clk(clk), .rst(rst0), .en(en0), .mode(mode0), .addr_valid(v0), .addr(addr0),
    .addr_ready(rdy0), .dout(dout0), .cur_idx(idx0), .wrap(wrap0));
  decoder_n_scan #(.N(3), .HOLD(1)) dut1 (
    .clk(clk), .rst(rst1), .en(en1), .mode(mode1), .addr_valid(v1), .addr(addr1),
    .addr_ready(rdy1), .dout(dout1), .cur_idx(idx1), .wrap(wrap1));
  decoder_n_scan #(.N(1), .HOLD(2)) dut2 (
    .clk(clk), .rst(rst2), .en(en2), .mode(mode2), .addr_valid(v2), .addr(addr2),
    .addr_ready(rdy2), .dout(dout2), .cur_idx(idx2), .wrap(wrap2));

  typedef struct {
    logic       rst, en, mode, valid;
    logic [1:0] addr;
    logic [3:0] dout;
    logic [1:0] idx;
    logic       wrap;
    logic       ready;
  } vec_t;

  typedef struct {
    logic [7:0] dout;
    logic [2:0] idx;
    logic       wrap;
    int         tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb0[$];
  exp_t sb1[$];
  exp_t sb2[$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s [step %0d]: got %0h expected %0h", name, tag, act, exp);
    end
  endtask

  task automatic addv(input logic r, input logic e, input logic m, input logic v,
                      input logic [1:0] a, input logic [3:0] d, input logic [1:0] i,
                      input logic w, input logic rdy, input int reps);
    vec_t t;
    t.rst = r; t.en = e; t.mode = m; t.valid = v; t.addr = a;
    t.dout = d; t.idx = i; t.wrap = w; t.ready = rdy;
    for (int k = 0; k < reps; k++) vecs.push_back(t);
  endtask

  task automatic pop0();
    exp_t x;
    if (sb0.size() == 0) begin
      check("sb0_empty", -1, 32'd1, 32'd0);
    end else begin
      x = sb0.pop_front();
      check("dut0_dout", x.tag, {28'd0, dout0}, {28'd0, x.dout[3:0]});
      check("dut0_idx", x.tag, {30'd0, idx0}, {30'd0, x.idx[1:0]});
      check("dut0_wrap", x.tag, {31'd0, wrap0}, {31'd0, x.wrap});
      check("dut0_onehot0", x.tag, 32'($onehot0(dout0)), 32'd1);
    end
  endtask

  task automatic pop12();
    exp_t x;
    if (sb1.size() == 0 || sb2.size() == 0) begin
      check("sb12_empty", -1, 32'd1, 32'd0);
    end else begin
      x = sb1.pop_front();
      check("dut1_dout", x.tag, {24'd0, dout1}, {24'd0, x.dout});
      check("dut1_idx", x.tag, {29'd0, idx1}, {29'd0, x.idx});
      check("dut1_wrap", x.tag, {31'd0, wrap1}, {31'd0, x.wrap});
      x = sb2.pop_front();
      check("dut2_dout", x.tag, {30'd0, dout2}, {30'd0, x.dout[1:0]});
      check("dut2_idx", x.tag, {31'd0, idx2}, {31'd0, x.idx[0:0]});
      check("dut2_wrap", x.tag, {31'd0, wrap2}, {31'd0, x.wrap});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    rst0 = 1; en0 = 0; mode0 = 0; v0 = 0; addr0 = '0;
    rst1 = 1; en1 = 0; mode1 = 0; v1 = 0; addr1 = '0;
    rst2 = 1; en2 = 0; mode2 = 0; v2 = 0; addr2 = '0;

    // rst en mode valid addr | dout idx wrap ready | repeat
    addv(1, 1, 1, 0, 2'd0, 4'b0000, 2'd0, 0, 0, 2);  // reset with scan requested
    addv(0, 1, 0, 1, 2'd2, 4'b0100, 2'd2, 0, 1, 1);  // direct accept
    addv(0, 1, 0, 0, 2'd0, 4'b0100, 2'd2, 0, 1, 5);  // hold while idle
    addv(0, 1, 1, 0, 2'd0, 4'b0100, 2'd2, 0, 0, 3);  // scan entry at idx 2
    addv(0, 1, 1, 0, 2'd0, 4'b1000, 2'd3, 0, 0, 3);
    addv(0, 1, 1, 0, 2'd0, 4'b0001, 2'd0, 1, 0, 1);  // wrap pulse
    addv(0, 1, 1, 0, 2'd0, 4'b0001, 2'd0, 0, 0, 2);
    addv(0, 1, 1, 0, 2'd0, 4'b0010, 2'd1, 0, 0, 3);
    addv(0, 1, 1, 0, 2'd0, 4'b0100, 2'd2, 0, 0, 3);
    addv(0, 1, 1, 0, 2'd0, 4'b1000, 2'd3, 0, 0, 2);
    addv(0, 0, 1, 1, 2'd1, 4'b0000, 2'd3, 0, 0, 1);  // disable mid-scan, valid ignored
    addv(0, 0, 1, 0, 2'd0, 4'b0000, 2'd3, 0, 0, 1);
    addv(0, 1, 1, 0, 2'd0, 4'b1000, 2'd3, 0, 0, 3);  // re-enable: full dwell on line 3
    addv(0, 1, 1, 0, 2'd0, 4'b0001, 2'd0, 1, 0, 1);
    addv(0, 1, 1, 0, 2'd0, 4'b0001, 2'd0, 0, 0, 2);
    addv(0, 1, 1, 0, 2'd0, 4'b0010, 2'd1, 0, 0, 2);
    addv(1, 1, 1, 0, 2'd0, 4'b0000, 2'd0, 0, 0, 1);  // reset mid-scan
    addv(0, 1, 1, 0, 2'd0, 4'b0001, 2'd0, 0, 0, 3);
    addv(0, 1, 1, 0, 2'd0, 4'b0010, 2'd1, 0, 0, 1);
    addv(0, 1, 0, 0, 2'd0, 4'b0010, 2'd1, 0, 1, 1);  // direct from scan keeps line
    addv(0, 1, 0, 1, 2'd3, 4'b1000, 2'd3, 0, 1, 1);
    addv(0, 0, 0, 1, 2'd1, 4'b0000, 2'd3, 0, 0, 1);  // en=0 beats valid
    addv(0, 1, 0, 0, 2'd0, 4'b0000, 2'd3, 0, 1, 1);  // direct from off stays blank
    addv(0, 1, 1, 0, 2'd0, 4'b1000, 2'd3, 0, 0, 3);
    addv(0, 1, 0, 0, 2'd0, 4'b1000, 2'd3, 0, 1, 1);  // mode change on last dwell cycle
    addv(0, 1, 1, 0, 2'd0, 4'b1000, 2'd3, 0, 0, 3);
    addv(0, 1, 1, 0, 2'd0, 4'b0001, 2'd0, 1, 0, 1);

    foreach (vecs[i]) begin
      @(negedge clk);
      if (sb0.size() > 0) pop0();
      rst0 = vecs[i].rst; en0 = vecs[i].en; mode0 = vecs[i].mode;
      v0 = vecs[i].valid; addr0 = vecs[i].addr;
      #1;
      check("dut0_ready", i, {31'd0, rdy0}, {31'd0, vecs[i].ready});
      e.dout = {4'd0, vecs[i].dout}; e.idx = {1'b0, vecs[i].idx};
      e.wrap = vecs[i].wrap; e.tag = i;
      sb0.push_back(e);
    end
    @(negedge clk);
    pop0();

    // Parameter sweep: one reset edge, then continuous scan on both small instances.
    rst1 = 1; en1 = 1; mode1 = 1; v1 = 1; addr1 = 3'd5;
    rst2 = 1; en2 = 1; mode2 = 1; v2 = 1; addr2 = 1'b1;
    e.dout = 8'd0; e.idx = 3'd0; e.wrap = 1'b0; e.tag = 100;
    sb1.push_back(e);
    sb2.push_back(e);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      pop12();
      rst1 = 0; rst2 = 0;
      #1;
      check("dut1_ready", 200 + k, {31'd0, rdy1}, 32'd0);
      check("dut2_ready", 200 + k, {31'd0, rdy2}, 32'd0);
      e.idx  = 3'(k % 8);
      e.dout = 8'(1 << (k % 8));
      e.wrap = (k > 0) && (k % 8 == 0);
      e.tag  = 200 + k;
      sb1.push_back(e);
      e.idx  = 3'((k / 2) % 2);
      e.dout = 8'(1 << ((k / 2) % 2));
      e.wrap = (k > 0) && (k % 4 == 0);
      sb2.push_back(e);
    end
    @(negedge clk);
    pop12();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
